// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and types for the PS/2 keyboard front end of the block shooter.
// Holds the default key make codes, the prefix codes and the frame-state encoding.
package ps2_key_decoder_pkg;

  localparam logic [7:0] KEY_A_DEF     = 8'h1C;
  localparam logic [7:0] KEY_D_DEF     = 8'h23;
  localparam logic [7:0] KEY_SPACE_DEF = 8'h29;
  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // A PS/2 frame is good when the data bits and the parity bit together hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-event bundle between the PS/2 decoder and its consumer (player-control FSM / shooting logic).
interface ps2_key_decoder_if;
  logic       consume;
  logic       a_pressed;
  logic       d_pressed;
  logic       space_pressed;
  logic       a_held;
  logic       d_held;
  logic       space_held;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    input  consume,
    output a_pressed, d_pressed, space_pressed,
    output a_held, d_held, space_held,
    output scan_code, scan_valid, frame_err
  );

  modport slave (
    output consume,
    input  a_pressed, d_pressed, space_pressed,
    input  a_held, d_held, space_held,
    input  scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and filters the raw lines, then assembles
// 11-bit frames into bytes with parity, stop-bit and inter-edge timeout checking.
module ps2_rx_frame
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_p0, clk_p1, dat_p0, dat_p1;
  logic          clk_f, clk_f_q;
  logic [FW-1:0] flt_cnt;
  logic          strobe;

  frame_state_t  state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    byte_n;
  logic          vld_n, err_n;

  // Stage p0/p1: two-flop synchronisers; idle-high lines reset to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_dat;
      dat_p1 <= dat_p0;
    end
  end

  // Filter: the clock only flips after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_f   <= 1'b1;
      clk_f_q <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_f_q <= clk_f;
      if (clk_p1 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign strobe = clk_f_q & ~clk_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      timer      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_n;
      timer      <= timer_n;
      rx_byte    <= byte_n;
      byte_valid <= vld_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    timer_n   = timer;
    byte_n    = rx_byte;
    vld_n     = 1'b0;
    err_n     = 1'b0;
    if (strobe) begin
      timer_n = '0;
      case (state)
        IDLE: begin
          // A high start bit is line noise, not a frame
          if (!dat_p1) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {dat_p1, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_p1;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_p1 && odd_parity_ok(shreg, par_bit)) begin
            byte_n = shreg;
            vld_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n = IDLE;
        err_n   = 1'b1;
        timer_n = '0;
      end else begin
        timer_n = timer + 1'b1;
      end
    end else begin
      timer_n = '0;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: turns received scan codes into held/pending key events for A, D
// and space; a pending press stays up until the consumer acknowledges it.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] KEY_A          = KEY_A_DEF,
  parameter logic [7:0] KEY_D          = KEY_D_DEF,
  parameter logic [7:0] KEY_SPACE      = KEY_SPACE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_key_decoder_if.master  key_if
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;
  logic       ext, brk;
  logic [2:0] held, pend;
  logic [2:0] hit, make_hit, brk_hit, pend_kept;
  logic       is_prefix;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_byte    (rx_byte),
    .byte_valid (rx_vld),
    .err        (rx_err)
  );

  // Bit order {space, d, a} is shared by hit, held and pend
  assign hit       = {rx_byte == KEY_SPACE, rx_byte == KEY_D, rx_byte == KEY_A};
  assign is_prefix = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);
  assign make_hit  = (rx_vld && !is_prefix && !ext && !brk) ? hit : 3'b000;
  assign brk_hit   = (rx_vld && !is_prefix && !ext &&  brk) ? hit : 3'b000;
  assign pend_kept = pend & ~{3{key_if.consume}};

  // Stage p1: key state updates one cycle after the byte arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      held <= '0;
      pend <= '0;
    end else begin
      // A fresh make overrides a same-cycle consume so the new press is not lost
      pend <= pend_kept | make_hit;
      held <= (held | make_hit) & ~brk_hit;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_vld) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign key_if.a_pressed     = pend[0];
  assign key_if.d_pressed     = pend[1];
  assign key_if.space_pressed = pend[2];
  assign key_if.a_held        = held[0];
  assign key_if.d_held        = held[1];
  assign key_if.space_held    = held[2];
  assign key_if.scan_code     = rx_byte;
  assign key_if.scan_valid    = rx_vld;
  assign key_if.frame_err     = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, scan codes checked by a scoreboard.
module tb_ps2_key_decoder;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk, ps2_dat;
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;
  int   obs_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_code;
  logic v, e;
  int   n;

  ps2_key_decoder_if kif();

  ps2_key_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .key_if  (kif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (kif.scan_valid) begin
        exp_code = 8'hxx;
        if (sb.size() > 0) exp_code = sb.pop_front();
        check("sb_scan_code", {24'h0, kif.scan_code}, {24'h0, exp_code});
      end
      if (kif.frame_err) obs_err++;
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic flip);
    return {1'b1, (~^d) ^ flip, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(15);
    ps2_clk = 1'b0;
    tick(30);
    ps2_clk = 1'b1;
    tick(15);
  endtask

  task automatic glitches();
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(10);
    end
  endtask

  task automatic wait_evt(input int budget, output logic vo, output logic eo, output int no);
    no = 0; vo = 1'b0; eo = 1'b0;
    while (no < budget && !vo && !eo) begin
      @(negedge clk);
      no++;
      vo = kif.scan_valid;
      eo = kif.frame_err;
    end
  endtask

  // Sends a whole frame and returns at the negedge where scan_valid/frame_err is seen,
  // with ps2_clk still low for the stop bit; release_clk() finishes it.
  task automatic send_frame(input logic [7:0] d, input logic flip, input int glitch_after,
                            output logic vo, output logic eo, output int no);
    logic [10:0] fb;
    fb = frame_bits(d, flip);
    for (int i = 0; i < 10; i++) begin
      ps2_bit(fb[i]);
      if (i == glitch_after) glitches();
    end
    ps2_dat = fb[10];
    tick(15);
    ps2_clk = 1'b0;
    wait_evt(60, vo, eo, no);
  endtask

  task automatic release_clk();
    ps2_clk = 1'b1;
    tick(20);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {kif.a_pressed, kif.d_pressed, kif.space_pressed, kif.a_held, kif.d_held,
                kif.space_held, kif.scan_valid, kif.frame_err}, 0);
    check({tag, "_code"}, {24'h0, kif.scan_code}, 0);
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; kif.consume = 1'b0;
    tick(3);
    check_all_zero("reset_state");
    reset = 1'b0;
    tick(5);

    // Test 1: make A, pending held until consumed
    sb.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, -1, v, e, n);
    check("t1_valid", v, 1);
    check("t1_err", e, 0);
    check("t1_pend_latency", kif.a_pressed, 0);
    tick(1);
    check("t1_a_pressed", kif.a_pressed, 1);
    check("t1_a_held", kif.a_held, 1);
    tick(3);
    check("t1_pend_hold", kif.a_pressed, 1);
    kif.consume = 1'b1;
    tick(1);
    kif.consume = 1'b0;
    check("t1_consumed", kif.a_pressed, 0);
    check("t1_held_stays", kif.a_held, 1);
    release_clk();

    // Test 2: break A, then extended D ignored
    sb.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, -1, v, e, n);
    release_clk();
    sb.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, -1, v, e, n);
    tick(1);
    check("t2_a_held_clr", kif.a_held, 0);
    check("t2_a_pressed", kif.a_pressed, 0);
    release_clk();
    sb.push_back(8'hE0);
    send_frame(8'hE0, 1'b0, -1, v, e, n);
    release_clk();
    sb.push_back(8'h23);
    send_frame(8'h23, 1'b0, -1, v, e, n);
    tick(1);
    check("t2_ext_d_held", kif.d_held, 0);
    check("t2_ext_d_pressed", kif.d_pressed, 0);
    release_clk();

    // Test 3: parity error, then good space
    send_frame(8'h29, 1'b1, -1, v, e, n);
    exp_err++;
    check("t3_err", e, 1);
    check("t3_no_valid", v, 0);
    tick(1);
    check("t3_space", {kif.space_pressed, kif.space_held}, 0);
    check("t3_code_kept", {24'h0, kif.scan_code}, 32'h23);
    release_clk();
    sb.push_back(8'h29);
    send_frame(8'h29, 1'b0, -1, v, e, n);
    tick(1);
    check("t3_space_pressed", kif.space_pressed, 1);
    check("t3_space_held", kif.space_held, 1);
    release_clk();

    // Test 4: timeout mid-frame, then good D (also shows ext was cleared)
    begin
      logic [10:0] fb;
      fb = frame_bits(8'h23, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(fb[i]);
    end
    wait_evt(TMO + 200, v, e, n);
    exp_err++;
    check("t4_timeout_err", e, 1);
    check("t4_no_valid", v, 0);
    check("t4_not_early", n >= TMO - 100, 1);
    tick(5);
    sb.push_back(8'h23);
    send_frame(8'h23, 1'b0, -1, v, e, n);
    check("t4_valid", v, 1);
    tick(1);
    check("t4_d_pressed", kif.d_pressed, 1);
    check("t4_d_held", kif.d_held, 1);
    release_clk();

    // Test 5: typematic make coincident with consume
    sb.push_back(8'h23);
    send_frame(8'h23, 1'b0, -1, v, e, n);
    kif.consume = 1'b1;
    tick(1);
    kif.consume = 1'b0;
    check("t5_d_wins", kif.d_pressed, 1);
    check("t5_space_consumed", kif.space_pressed, 0);
    release_clk();

    // Test 6: clock glitches mid-frame are filtered out
    sb.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 3, v, e, n);
    check("t6_glitch_valid", v, 1);
    check("t6_glitch_err", e, 0);
    tick(1);
    check("t6_a_pressed", kif.a_pressed, 1);
    release_clk();

    // Reset mid-DATA clears everything and drops the partial byte
    begin
      logic [10:0] fb;
      fb = frame_bits(8'h29, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(fb[i]);
    end
    reset = 1'b1;
    tick(1);
    check_all_zero("t6_reset");
    reset = 1'b0;
    tick(5);
    sb.push_back(8'h29);
    send_frame(8'h29, 1'b0, -1, v, e, n);
    check("t6_post_reset_valid", v, 1);
    tick(1);
    check("t6_post_reset_space", kif.space_pressed, 1);
    check("t6_post_reset_a", kif.a_held, 0);
    release_clk();

    check("sb_drained", sb.size(), 0);
    check("err_count", obs_err, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
